dcache_2way_wb: RTL and testbench

Parametrised two-way set-associative, write-back, write-allocate data cache. It sits between the datapath's data port and data memory and replaces the fixed 4-line direct-mapped D-cache. It adds configurable geometry and memory latency, per-set LRU replacement, and a single request/ready handshake. It also exposes access and hit counters for performance measurement.

---
 rtl/dcache_2way_wb.sv | 198 +++++++++++++++++++
 tb/tb_dcache_2way_wb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_2way_wb.sv
// Two-way set-associative write-back, write-allocate data cache.
// Hits complete in the request cycle; misses fill a whole line from memory.
module dcache_2way_wb #(
  parameter int WORD_SIZE   = 16,
  parameter int SETS        = 4,
  parameter int LINE_WORDS  = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            req_read,
  input  logic                            req_write,
  input  logic [WORD_SIZE-1:0]            req_addr,
  input  logic [WORD_SIZE-1:0]            req_wdata,
  output logic [WORD_SIZE-1:0]            rsp_rdata,
  output logic                            ready,
  output logic                            hit,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [LINE_WORDS*WORD_SIZE-1:0] mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  output logic [15:0]                     access_cnt,
  output logic [15:0]                     hit_cnt
);

  localparam int INDEX_W  = $clog2(SETS);
  localparam int OFFSET_W = $clog2(LINE_WORDS);
  localparam int TAG_W    = WORD_SIZE - INDEX_W - OFFSET_W;
  localparam int LINE_W   = LINE_WORDS * WORD_SIZE;
  localparam int CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } state_t;

  state_t state;
  state_t stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic victim;
  logic victimNext;

  logic [1:0][SETS-1:0] valid;
  logic [1:0][SETS-1:0] dirty;
  logic [SETS-1:0]      lru;
  logic [TAG_W-1:0]     tags  [2][SETS];
  logic [LINE_W-1:0]    lines [2][SETS];

  logic [TAG_W-1:0]    reqTag;
  logic [INDEX_W-1:0]  reqIdx;
  logic [OFFSET_W-1:0] reqOff;
  logic                isReq;
  logic                isWr;
  logic [1:0]          hitWay;
  logic                anyHit;
  logic                missVictim;
  logic                useWay;
  logic                fillDone;
  logic [LINE_W-1:0]   useLine;

  assign reqTag = req_addr[WORD_SIZE-1 -: TAG_W];
  assign reqIdx = req_addr[OFFSET_W +: INDEX_W];
  assign reqOff = req_addr[OFFSET_W-1:0];
  assign isReq  = req_read | req_write;
  assign isWr   = req_write & ~req_read;

  assign hitWay[0] = valid[0][reqIdx] && (tags[0][reqIdx] == reqTag);
  assign hitWay[1] = valid[1][reqIdx] && (tags[1][reqIdx] == reqTag);
  assign anyHit    = |hitWay;

  assign missVictim = !valid[0][reqIdx] ? 1'b0 :
                      !valid[1][reqIdx] ? 1'b1 : lru[reqIdx];

  // Next state, memory strobes and response for the current request
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    victimNext = victim;
    ready      = 1'b0;
    hit        = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    useWay     = 1'b0;
    fillDone   = 1'b0;
    rsp_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (isReq) begin
          if (anyHit) begin
            ready  = 1'b1;
            hit    = 1'b1;
            useWay = hitWay[1];
          end else begin
            victimNext = missVictim;
            cntNext    = '0;
            if (valid[missVictim][reqIdx] && dirty[missVictim][reqIdx])
              stateNext = WB;
            else
              stateNext = FILL;
          end
        end
      end
      WB: begin
        mem_write = 1'b1;
        mem_addr  = {tags[victim][reqIdx], reqIdx, {OFFSET_W{1'b0}}};
        mem_wdata = lines[victim][reqIdx];
        if (cnt == CNT_LAST) begin
          cntNext   = '0;
          stateNext = FILL;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {reqTag, reqIdx, {OFFSET_W{1'b0}}};
        if (cnt == CNT_LAST) begin
          cntNext   = '0;
          fillDone  = 1'b1;
          stateNext = RESP;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        ready     = 1'b1;
        useWay    = victim;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    useLine = lines[useWay][reqIdx];
    if (ready && req_read)
      rsp_rdata = useLine[reqOff*WORD_SIZE +: WORD_SIZE];
  end

  // FSM state, latency counter and captured victim way
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      victim <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      victim <= victimNext;
    end
  end

  // Valid, dirty and LRU bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
      dirty <= '0;
      lru   <= '0;
    end else begin
      if (fillDone) begin
        valid[victim][reqIdx] <= 1'b1;
        dirty[victim][reqIdx] <= 1'b0;
      end
      if (ready) begin
        lru[reqIdx] <= ~useWay;
        if (isWr)
          dirty[useWay][reqIdx] <= 1'b1;
      end
    end
  end

  // Tag and line storage: line fill and word merge
  always_ff @(posedge clk) begin
    if (fillDone) begin
      lines[victim][reqIdx] <= mem_rdata;
      tags[victim][reqIdx]  <= reqTag;
    end
    if (ready && isWr)
      lines[useWay][reqIdx][reqOff*WORD_SIZE +: WORD_SIZE] <= req_wdata;
  end

  // Access and hit counters, wrapping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      access_cnt <= '0;
      hit_cnt    <= '0;
    end else if (ready) begin
      access_cnt <= access_cnt + 16'd1;
      if (hit)
        hit_cnt <= hit_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_dcache_2way_wb.sv
// Scoreboard bench for dcache_2way_wb.
// Golden word memory predicts read data; line memory models the backing store.
`timescale 1ns/1ps
module tb_dcache_2way_wb;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] rsp_rdata;
  logic        ready;
  logic        hit;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [15:0] access_cnt;
  logic [15:0] hit_cnt;

  dcache_2way_wb #(
    .WORD_SIZE(16),
    .SETS(4),
    .LINE_WORDS(4),
    .MEM_LATENCY(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_read(req_read),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_rdata(rsp_rdata),
    .ready(ready),
    .hit(hit),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .access_cnt(access_cnt),
    .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  logic [15:0] mem  [1024];
  logic [15:0] gold [1024];
  logic [9:0]  mb;

  assign mb = {mem_addr[9:2], 2'b00};
  assign mem_rdata = {mem[mb + 10'd3], mem[mb + 10'd2],
                      mem[mb + 10'd1], mem[mb]};

  // Backing store absorbs write-back lines
  always @(posedge clk) begin
    if (mem_write)
      for (int k = 0; k < 4; k++)
        mem[mb + 10'(k)] <= mem_wdata[k*16 +: 16];
  end

  typedef struct {
    logic [15:0] data;
    bit          hit;
    int          lat;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad = 0;
  int expAcc = 0;
  int expHit = 0;
  int cyc;
  int nRd;
  int nWr;
  int nBoth;
  logic [15:0] lastRdA;
  logic [15:0] lastWrA;
  logic [63:0] lastWd;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic doReq(input string tag, input bit rd, input bit wr,
                       input logic [15:0] a, input logic [15:0] wd,
                       input bit eh, input int elat);
    exp_t e;
    e.hit  = eh;
    e.lat  = elat;
    e.data = rd ? gold[a[9:0]] : 16'h0;
    if (wr && !rd)
      gold[a[9:0]] = wd;
    sbq.push_back(e);
    req_read  = rd;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    cyc = 0;
    nRd = 0;
    nWr = 0;
    nBoth = 0;
    #1;
    while (!ready && cyc < 40) begin
      if (mem_read) begin
        nRd++;
        lastRdA = mem_addr;
      end
      if (mem_write) begin
        nWr++;
        lastWrA = mem_addr;
        lastWd  = mem_wdata;
      end
      if (mem_read && mem_write)
        nBoth++;
      @(negedge clk);
      cyc++;
    end
    e = sbq.pop_front();
    if (!ready) begin
      chk({tag, "_timeout"}, 64'(cyc), 64'(e.lat));
    end else begin
      chk({tag, "_lat"}, 64'(cyc), 64'(e.lat));
      chk({tag, "_hit"}, 64'(hit), 64'(e.hit));
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.data));
      expAcc++;
      if (e.hit)
        expHit++;
    end
    @(negedge clk);
    req_read  = 1'b0;
    req_write = 1'b0;
    chk({tag, "_acc"}, 64'(access_cnt), 64'(expAcc));
    chk({tag, "_hitcnt"}, 64'(hit_cnt), 64'(expHit));
    chk({tag, "_excl"}, 64'(nBoth), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = 16'hA000 ^ 16'(i * 7);
    mem[16'h10] = 16'h1111;
    mem[16'h11] = 16'h2222;
    mem[16'h12] = 16'h3333;
    mem[16'h13] = 16'h4444;
    for (int i = 0; i < 1024; i++)
      gold[i] = mem[i];

    #12;
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_mrd", 64'(mem_read), 64'd0);
    chk("rst_mwr", 64'(mem_write), 64'd0);
    chk("rst_acc", 64'(access_cnt), 64'd0);
    chk("rst_hcnt", 64'(hit_cnt), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Cold read then hit
    doReq("cold", 1, 0, 16'h0010, 16'h0, 0, 5);
    chk("cold_nrd", 64'(nRd), 64'd4);
    chk("cold_addr", 64'(lastRdA), 64'h0010);
    chk("cold_nwr", 64'(nWr), 64'd0);
    doReq("hit13", 1, 0, 16'h0013, 16'h0, 1, 0);

    // LRU replacement
    doReq("lru20", 1, 0, 16'h0020, 16'h0, 0, 5);
    doReq("lru11", 1, 0, 16'h0011, 16'h0, 1, 0);
    doReq("lru30", 1, 0, 16'h0030, 16'h0, 0, 5);
    chk("lru30_nwr", 64'(nWr), 64'd0);
    doReq("lru12", 1, 0, 16'h0012, 16'h0, 1, 0);
    doReq("lru20b", 1, 0, 16'h0020, 16'h0, 0, 5);

    // Dirty eviction
    doReq("wbeef", 0, 1, 16'h0011, 16'hBEEF, 1, 0);
    doReq("d20", 1, 0, 16'h0020, 16'h0, 1, 0);
    doReq("d30", 1, 0, 16'h0030, 16'h0, 0, 9);
    chk("d30_nwr", 64'(nWr), 64'd4);
    chk("d30_wa", 64'(lastWrA), 64'h0010);
    chk("d30_wd", 64'(lastWd[31:16]), 64'hBEEF);
    chk("d30_nrd", 64'(nRd), 64'd4);
    chk("d30_ra", 64'(lastRdA), 64'h0030);

    // Write miss allocate in set 1
    doReq("wmiss", 0, 1, 16'h0046, 16'h1234, 0, 5);
    chk("wmiss_ra", 64'(lastRdA), 64'h0044);
    doReq("wm46", 1, 0, 16'h0046, 16'h0, 1, 0);
    doReq("wm56", 1, 0, 16'h0056, 16'h0, 0, 5);
    doReq("wm66", 1, 0, 16'h0066, 16'h0, 0, 9);
    chk("wm66_nwr", 64'(nWr), 64'd4);
    chk("wm66_wa", 64'(lastWrA), 64'h0044);
    doReq("wm46b", 1, 0, 16'h0046, 16'h0, 0, 5);

    // Reset in the middle of a fill
    req_read = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mrd", 64'(mem_read), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_mrd0", 64'(mem_read), 64'd0);
    chk("mid_rdy0", 64'(ready), 64'd0);
    chk("mid_acc0", 64'(access_cnt), 64'd0);
    chk("mid_hcnt0", 64'(hit_cnt), 64'd0);
    expAcc = 0;
    expHit = 0;
    @(negedge clk);
    req_read = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    doReq("post10", 1, 0, 16'h0010, 16'h0, 0, 5);

    // Read and write together act as a read
    doReq("rw12", 1, 1, 16'h0012, 16'hDEAD, 1, 0);
    doReq("rw12rd", 1, 0, 16'h0012, 16'h0, 1, 0);
    doReq("rw20", 1, 0, 16'h0020, 16'h0, 0, 5);
    doReq("rw30", 1, 0, 16'h0030, 16'h0, 0, 5);
    chk("rw30_nwr", 64'(nWr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
